// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
// Holds the register-address width, register count, default counter width
// and the packed issue-slot struct used by the top and its counter cells.
package reg_scoreboard_pkg;

  localparam int REG_AW    = 5;   // architectural register address width
  localparam int NREG      = 32;  // architectural register count (r0 untracked)
  localparam int CNT_W_DEF = 2;   // default pending-writer counter width

  // One issue slot as presented by the decode/issue stage.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rj;
    logic [REG_AW-1:0] rk;
    logic [REG_AW-1:0] rd;
    logic              we;
  } iss_slot_t;

  // Population count of two single-bit events, used for the 0..2
  // increment/decrement amounts of one counter.
  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_cnt_cell.sv
// Pending-writer counter for a single architectural register.
// Ports: clk/aresetn (sync, active-low), flush_i, inc_i/dec_i (0..2 each),
//        cnt_o (registered count), eff_o (count minus same-cycle retirements).
// Next count is cnt + inc - dec clamped to [0, max]; flush forces zero.
module sb_cnt_cell
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             flush_i,
  input  logic [1:0]       inc_i,
  input  logic [1:0]       dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] eff_o
);

  localparam logic [CNT_W+1:0] MAX_X = (CNT_W+2)'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+1:0] cnt_x, inc_x, dec_x, sum_x, res_x, eff_x;
  logic             underflow;

  // Two guard bits so that cnt + 2 never wraps before the clamps.
  assign cnt_x = {2'b00, cnt_q};
  assign inc_x = {{CNT_W{1'b0}}, inc_i};
  assign dec_x = {{CNT_W{1'b0}}, dec_i};
  assign sum_x = cnt_x + inc_x;

  // Retiring more writes than are pending means the writeback stream and
  // the issue stream disagree; clamp rather than wrap to a huge count.
  assign underflow = (sum_x < dec_x);

  always_comb begin
    res_x = '0;
    if (!underflow) begin
      res_x = sum_x - dec_x;
    end
    // Issue gating keeps eff + inc within max, so this clamp is a backstop.
    if (res_x > MAX_X) begin
      res_x = MAX_X;
    end
    cnt_d = res_x[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A same-cycle writeback already carries its data through the register
  // file bypass, so it no longer counts as a hazard for readers.
  assign eff_x = (cnt_x >= dec_x) ? (cnt_x - dec_x) : '0;
  assign eff_o = eff_x[CNT_W-1:0];
  assign cnt_o = cnt_q;

  a_no_underflow : assert property (@(posedge clk) disable iff (!aresetn || flush_i) !underflow)
    else $error("sb_cnt_cell: writeback retired a register with no pending writer");

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard ahead of the 4R/2W register file.
// Ports: clk, aresetn (sync active-low), flush; issue slots 0/1
//        (valid/rj/rk/rd/we in, ready out); writeback ports 1/2 (we/waddr);
//        busy_mask (counter nonzero per register, bit 0 always 0).
// Optional macro SB_STALL_CNT_EN adds a 32-bit stall_cnt output counting
// cycles where slot0 is valid but held back (flush cycles excluded).
module reg_scoreboard #(
  parameter int NREG  = reg_scoreboard_pkg::NREG,
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W_DEF
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            flush,
  input  logic            iss0_valid,
  input  logic [4:0]      iss0_rj,
  input  logic [4:0]      iss0_rk,
  input  logic [4:0]      iss0_rd,
  input  logic            iss0_we,
  output logic            iss0_ready,
  input  logic            iss1_valid,
  input  logic [4:0]      iss1_rj,
  input  logic [4:0]      iss1_rk,
  input  logic [4:0]      iss1_rd,
  input  logic            iss1_we,
  output logic            iss1_ready,
  input  logic            wb_we1,
  input  logic [4:0]      wb_waddr1,
  input  logic            wb_we2,
  input  logic [4:0]      wb_waddr2,
  output logic [NREG-1:0] busy_mask
`ifdef SB_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  import reg_scoreboard_pkg::*;

  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'((1 << CNT_W) - 1);

  iss_slot_t s0, s1;
  assign s0 = '{valid: iss0_valid, rj: iss0_rj, rk: iss0_rk, rd: iss0_rd, we: iss0_we};
  assign s1 = '{valid: iss1_valid, rj: iss1_rj, rk: iss1_rk, rd: iss1_rd, we: iss1_we};

  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] eff [NREG];
  logic             fire0, fire1;
  logic             ok0, ok1, dep1, w0;
  logic             same_rd;

  // r0 is hard-wired: never pending, never a hazard.
  assign cnt[0] = '0;
  assign eff[0] = '0;

  // Readiness only looks at effective counts, which depend on writebacks
  // and not on this cycle's issues, so fire -> inc never feeds back.
  assign fire0 = s0.valid & iss0_ready;
  assign fire1 = s1.valid & iss1_ready;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_cell
      logic [1:0] inc, dec;
      assign inc = count2(fire0 & s0.we & (s0.rd == REG_AW'(r)),
                          fire1 & s1.we & (s1.rd == REG_AW'(r)));
      assign dec = count2(wb_we1 & (wb_waddr1 == REG_AW'(r)),
                          wb_we2 & (wb_waddr2 == REG_AW'(r)));

      sb_cnt_cell #(.CNT_W(CNT_W)) u_cell (
        .clk     (clk),
        .aresetn (aresetn),
        .flush_i (flush),
        .inc_i   (inc),
        .dec_i   (dec),
        .cnt_o   (cnt[r]),
        .eff_o   (eff[r])
      );
    end
  endgenerate

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_mask[i] = |cnt[i];
    end
  end

  always_comb begin
    // Slot0: sources clear and destination counter has headroom.
    ok0 = 1'b1;
    if ((s0.rj != '0) && (eff[s0.rj] != '0)) ok0 = 1'b0;
    if ((s0.rk != '0) && (eff[s0.rk] != '0)) ok0 = 1'b0;
    if (s0.we && (s0.rd != '0) && !({1'b0, eff[s0.rd]} < MAX_C)) ok0 = 1'b0;

    // Slot1 additionally sees slot0's destination as in flight, both as a
    // RAW source and as one extra writer when both target the same rd.
    w0      = s0.we && (s0.rd != '0);
    same_rd = w0 && (s0.rd == s1.rd);
    dep1    = w0 && ((s1.rj == s0.rd) || (s1.rk == s0.rd));

    ok1 = 1'b1;
    if ((s1.rj != '0) && (eff[s1.rj] != '0)) ok1 = 1'b0;
    if ((s1.rk != '0) && (eff[s1.rk] != '0)) ok1 = 1'b0;
    if (s1.we && (s1.rd != '0) &&
        !(({1'b0, eff[s1.rd]} + {{CNT_W{1'b0}}, same_rd}) < MAX_C)) ok1 = 1'b0;
  end

  assign iss0_ready = aresetn & ~flush & ok0;
  // In-order pair: slot1 only goes alongside a firing slot0.
  assign iss1_ready = iss0_ready & s0.valid & ok1 & ~dep1;

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (s0.valid & ~iss0_ready & ~flush) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        aresetn;
  logic        flush;
  logic        iss0_valid, iss0_we, iss1_valid, iss1_we;
  logic [4:0]  iss0_rj, iss0_rk, iss0_rd, iss1_rj, iss1_rk, iss1_rd;
  logic        iss0_ready, iss1_ready;
  logic        wb_we1, wb_we2;
  logic [4:0]  wb_waddr1, wb_waddr2;
  logic [31:0] busy_mask;
`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] stall_snap;
`endif

  int          tests_run;
  int          tests_failed;
  int          mcnt [32];
  logic [31:0] exp_q [$];
  logic [31:0] exp_mask;

  reg_scoreboard dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .flush      (flush),
    .iss0_valid (iss0_valid),
    .iss0_rj    (iss0_rj),
    .iss0_rk    (iss0_rk),
    .iss0_rd    (iss0_rd),
    .iss0_we    (iss0_we),
    .iss0_ready (iss0_ready),
    .iss1_valid (iss1_valid),
    .iss1_rj    (iss1_rj),
    .iss1_rk    (iss1_rk),
    .iss1_rd    (iss1_rd),
    .iss1_we    (iss1_we),
    .iss1_ready (iss1_ready),
    .wb_we1     (wb_we1),
    .wb_waddr1  (wb_waddr1),
    .wb_we2     (wb_we2),
    .wb_waddr2  (wb_waddr2),
    .busy_mask  (busy_mask)
`ifdef SB_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_s0(input logic v, input logic [4:0] rj, input logic [4:0] rk,
                        input logic [4:0] rd, input logic we);
    iss0_valid = v; iss0_rj = rj; iss0_rk = rk; iss0_rd = rd; iss0_we = we;
  endtask

  task automatic set_s1(input logic v, input logic [4:0] rj, input logic [4:0] rk,
                        input logic [4:0] rd, input logic we);
    iss1_valid = v; iss1_rj = rj; iss1_rk = rk; iss1_rd = rd; iss1_we = we;
  endtask

  task automatic set_wb(input logic we1, input logic [4:0] a1,
                        input logic we2, input logic [4:0] a2);
    wb_we1 = we1; wb_waddr1 = a1; wb_we2 = we2; wb_waddr2 = a2;
  endtask

  task automatic idle();
    flush = 1'b0;
    set_s0(0, 0, 0, 0, 0);
    set_s1(0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
  endtask

  // Model update for the coming edge. f0/f1 are the fires the test expects;
  // the resulting busy mask is queued and the clock advanced.
  task automatic advance(input bit f0, input bit f1);
    logic [31:0] m;
    if (!aresetn || flush) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (f0 && iss0_we && iss0_rd != 0) mcnt[iss0_rd]++;
      if (f1 && iss1_we && iss1_rd != 0) mcnt[iss1_rd]++;
      if (wb_we1 && wb_waddr1 != 0 && mcnt[wb_waddr1] > 0) mcnt[wb_waddr1]--;
      if (wb_we2 && wb_waddr2 != 0 && mcnt[wb_waddr2] > 0) mcnt[wb_waddr2]--;
    end
    m = '0;
    for (int i = 1; i < 32; i++) m[i] = (mcnt[i] != 0);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    idle();
    set_s0(1, 0, 0, 1, 1);
    set_s1(1, 0, 0, 2, 1);
    @(posedge clk); #1;
    #2;
    tests_run++;
    if (iss0_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_iss0_ready: got %b expected 0", iss0_ready);
    end
    tests_run++;
    if (iss1_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_iss1_ready: got %b expected 0", iss1_ready);
    end
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL reset_busy: got %h expected %h", busy_mask, exp_mask);
    end
    aresetn = 1'b1;
    idle();
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL post_reset_busy: got %h expected %h", busy_mask, exp_mask);
    end
  endtask

  task automatic test_round_trip();
    set_s0(1, 0, 0, 4, 1);
    #2; tests_run++;
    if (iss0_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rt_issue_ready: got %b expected 1", iss0_ready);
    end
    advance(1, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask[4] !== 1'b1) begin
      tests_failed++; $display("FAIL rt_busy_set: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
    set_wb(1, 4, 0, 0);
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask[4] !== 1'b0) begin
      tests_failed++; $display("FAIL rt_busy_clear: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
  endtask

  task automatic test_raw_bypass();
    set_s0(1, 0, 0, 4, 1);
    advance(1, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL raw_setup_busy: got %h expected %h", busy_mask, exp_mask);
    end
    set_s0(1, 4, 0, 0, 0);
    #2; tests_run++;
    if (iss0_ready !== 1'b0) begin
      tests_failed++; $display("FAIL raw_hazard_rj: got %b expected 0", iss0_ready);
    end
`ifdef SB_STALL_CNT_EN
    stall_snap = stall_cnt;
`endif
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL raw_hold_busy: got %h expected %h", busy_mask, exp_mask);
    end
`ifdef SB_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== stall_snap + 32'd1) begin
      tests_failed++; $display("FAIL stall_incr: got %0d expected %0d", stall_cnt, stall_snap + 32'd1);
    end
`endif
    set_s0(1, 0, 4, 0, 0);
    #2; tests_run++;
    if (iss0_ready !== 1'b0) begin
      tests_failed++; $display("FAIL raw_hazard_rk: got %b expected 0", iss0_ready);
    end
    set_wb(0, 0, 1, 4);
    #2; tests_run++;
    if (iss0_ready !== 1'b1) begin
      tests_failed++; $display("FAIL raw_bypass: got %b expected 1", iss0_ready);
    end
    advance(1, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL raw_bypass_busy: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
  endtask

  task automatic test_intra_pair();
    set_s0(1, 0, 0, 5, 1);
    set_s1(1, 0, 5, 2, 0);
    #2; tests_run++;
    if (iss0_ready !== 1'b1 || iss1_ready !== 1'b0) begin
      tests_failed++; $display("FAIL pair_dep: got %b%b expected 10", iss0_ready, iss1_ready);
    end
    iss0_we = 1'b0;
    #1; tests_run++;
    if (iss1_ready !== 1'b1) begin
      tests_failed++; $display("FAIL pair_nodep: got %b expected 1", iss1_ready);
    end
    iss0_valid = 1'b0;
    #1; tests_run++;
    if (iss1_ready !== 1'b0) begin
      tests_failed++; $display("FAIL pair_inorder: got %b expected 0", iss1_ready);
    end
    idle();
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL pair_busy: got %h expected %h", busy_mask, exp_mask);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      set_s0(1, 0, 0, 6, 1);
      #2; tests_run++;
      if (iss0_ready !== 1'b1) begin
        tests_failed++; $display("FAIL sat_fill%0d: got %b expected 1", i, iss0_ready);
      end
      advance(1, 0);
      exp_mask = exp_q.pop_front(); tests_run++;
      if (busy_mask !== exp_mask) begin
        tests_failed++; $display("FAIL sat_fill_busy%0d: got %h expected %h", i, busy_mask, exp_mask);
      end
    end
    #2; tests_run++;
    if (iss0_ready !== 1'b0) begin
      tests_failed++; $display("FAIL sat_full: got %b expected 0", iss0_ready);
    end
    set_wb(1, 6, 0, 0);
    #2; tests_run++;
    if (iss0_ready !== 1'b1) begin
      tests_failed++; $display("FAIL sat_wb_room: got %b expected 1", iss0_ready);
    end
    advance(1, 0);
    exp_mask = exp_q.pop_front();
    // Count is 3 again: with one writeback slot1 to the same rd has no room.
    set_s1(1, 0, 0, 6, 1);
    #2; tests_run++;
    if (iss0_ready !== 1'b1 || iss1_ready !== 1'b0) begin
      tests_failed++; $display("FAIL sat_pair_room: got %b%b expected 10", iss0_ready, iss1_ready);
    end
    set_s0(0, 0, 0, 0, 0);
    set_s1(0, 0, 0, 0, 0);
    set_wb(1, 6, 1, 6);
    advance(0, 0);
    exp_mask = exp_q.pop_front();
    // Count 1: both slots to r6 fit exactly (1 + 1 < 3).
    set_wb(0, 0, 0, 0);
    set_s0(1, 0, 0, 6, 1);
    set_s1(1, 0, 0, 6, 1);
    #2; tests_run++;
    if (iss0_ready !== 1'b1 || iss1_ready !== 1'b1) begin
      tests_failed++; $display("FAIL sat_pair_fit: got %b%b expected 11", iss0_ready, iss1_ready);
    end
    advance(1, 1);
    exp_mask = exp_q.pop_front();
    idle();
    set_wb(1, 6, 1, 6);
    advance(0, 0);
    exp_mask = exp_q.pop_front();
    set_wb(1, 6, 0, 0);
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask[6] !== 1'b0) begin
      tests_failed++; $display("FAIL sat_drain: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
  endtask

  task automatic test_dual_wb_r0();
    set_s0(1, 0, 0, 7, 1);
    set_s1(1, 0, 0, 7, 1);
    #2; tests_run++;
    if (iss0_ready !== 1'b1 || iss1_ready !== 1'b1) begin
      tests_failed++; $display("FAIL dual_issue: got %b%b expected 11", iss0_ready, iss1_ready);
    end
    advance(1, 1);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL dual_busy: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
    set_wb(1, 7, 1, 7);
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask[7] !== 1'b0) begin
      tests_failed++; $display("FAIL dual_wb: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
    set_s0(1, 0, 0, 0, 1);
    #2; tests_run++;
    if (iss0_ready !== 1'b1) begin
      tests_failed++; $display("FAIL r0_ready: got %b expected 1", iss0_ready);
    end
    advance(1, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask !== 32'h0) begin
      tests_failed++; $display("FAIL r0_untracked: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
  endtask

  task automatic test_flush();
    set_s0(1, 0, 0, 8, 1);
    set_s1(1, 0, 0, 9, 1);
    advance(1, 1);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL flush_setup: got %h expected %h", busy_mask, exp_mask);
    end
    flush = 1'b1;
    set_s0(1, 0, 0, 10, 1);
    set_s1(0, 0, 0, 0, 0);
    #2; tests_run++;
    if (iss0_ready !== 1'b0) begin
      tests_failed++; $display("FAIL flush_ready: got %b expected 0", iss0_ready);
    end
`ifdef SB_STALL_CNT_EN
    stall_snap = stall_cnt;
`endif
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask !== 32'h0) begin
      tests_failed++; $display("FAIL flush_clear: got %h expected %h", busy_mask, exp_mask);
    end
`ifdef SB_STALL_CNT_EN
    tests_run++;
    if (stall_cnt !== stall_snap) begin
      tests_failed++; $display("FAIL stall_on_flush: got %0d expected %0d", stall_cnt, stall_snap);
    end
`endif
    idle();
    set_s0(1, 8, 9, 0, 0);
    #2; tests_run++;
    if (iss0_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_after: got %b expected 1", iss0_ready);
    end
    advance(1, 0);
    exp_mask = exp_q.pop_front();
    idle();
  endtask

  task automatic test_back_to_back();
    set_s0(1, 0, 0, 11, 1);
    advance(1, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask) begin
      tests_failed++; $display("FAIL b2b_c1: got %h expected %h", busy_mask, exp_mask);
    end
    set_wb(1, 11, 0, 0);
    #2; tests_run++;
    if (iss0_ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_ready: got %b expected 1", iss0_ready);
    end
    advance(1, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask[11] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_c2: got %h expected %h", busy_mask, exp_mask);
    end
    set_s0(0, 0, 0, 0, 0);
    advance(0, 0);
    exp_mask = exp_q.pop_front(); tests_run++;
    if (busy_mask !== exp_mask || busy_mask[11] !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_c3: got %h expected %h", busy_mask, exp_mask);
    end
    idle();
  endtask

  initial begin
    clk = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    aresetn = 1'b0;
    idle();
    test_reset();
    test_round_trip();
    test_raw_bypass();
    test_intra_pair();
    test_saturation();
    test_dual_wb_r0();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
